sample_vector_gen: RTL and testbench
====================================

// Module: sample_vector_gen
// PURPOSE
//  Upstream stimulus stage for sim_sample: drives its data_in/enable pair with a bounded burst of
//  pseudo-random bytes from a 32-bit LFSR. Replaces hand-fed vectors with a reproducible, seedable
//  stream. Includes warm-up idle cycles, hold (pause) and done/busy status for the controlling bench.
// PARAMETERS
//  WARM_CYCLES   10            idle cycles (enable low) between start and first emitted byte; >=1
//  SEED_DEFAULT  32'h0000_0001 LFSR value after reset
//  LEN_W         10            width of burst_len/vec_count (matches sim_sample count width)
// PORTS
//  sim_clk    in   1      single clock, all logic on posedge
//  reset      in   1      synchronous, active-high
//  start      in   1      begin a burst; sampled only in IDLE
//  burst_len  in   LEN_W  bytes to emit; latched when start is accepted
//  load_seed  in   1      load seed into LFSR; honoured only in IDLE
//  seed       in   32     seed value; 0 is replaced by 32'h1
//  hold       in   1      pause emission while high (RUN only)
//  data_out   out  8      byte to sim_sample data_in
//  enable_out out  1      to sim_sample enable; high exactly on cycles a byte is emitted
//  busy       out  1      high in WARMUP and RUN
//  done       out  1      one-cycle pulse at burst end
//  vec_count  out  LEN_W  bytes emitted in current/last burst
// BEHAVIOUR
//  - Reset (sync, high): state=IDLE, lfsr=SEED_DEFAULT, data_out=0, enable_out=0, busy=0, done=0,
//    vec_count=0. Reset wins over every other input; reset mid-burst aborts with no done pulse.
//  - All outputs registered. FSM states: IDLE, WARMUP, RUN, DONE.
//  - IDLE: load_seed=1 -> lfsr<=(seed==0)?1:seed. start=1 -> latch burst_len, vec_count<=0,
//    warm counter<=0, go WARMUP. start and load_seed same cycle: seed loads, burst starts.
//    burst_len==0 with start -> go DONE directly (no enable).
//  - WARMUP: busy=1, enable_out=0 for exactly WARM_CYCLES cycles, then RUN.
//  - RUN: each cycle with hold=0: enable_out=1, data_out=lfsr[7:0], lfsr advances, vec_count+1.
//    hold=1: enable_out=0, data_out/lfsr/vec_count hold. After the burst_len-th byte -> DONE.
//  - DONE: one cycle, done=1, busy=0, enable_out=0, then IDLE. vec_count held until next start.
//  - LFSR step (Fibonacci, x^32+x^22+x^2+x+1): lfsr<={lfsr[30:0], lfsr[31]^lfsr[21]^lfsr[1]^lfsr[0]}.
//    Advances only on emitted bytes; state persists across bursts (no reseed on start).
//  - start, load_seed outside IDLE are ignored. hold outside RUN is ignored.
//  - Latency: start sampled at edge N -> first enable_out high in cycle N+1+WARM_CYCLES (hold=0).
//  - vec_count never wraps: max burst 2^LEN_W-1 bytes.
// TESTING
//  1. Reset 10 cycles, load_seed seed=1, start burst_len=4, hold=0 -> data_out 01,03,06,0D with
//     enable_out high 4 consecutive cycles; done pulse next cycle; vec_count=4.
//  2. WARM_CYCLES=10: count cycles from start edge to first enable_out -> exactly 11; busy high throughout.
//  3. burst_len=6, hold high 3 cycles after 2nd byte -> enable_out low 3 cycles, data_out frozen,
//     remaining 4 bytes continue the sequence; total enable_out-high cycles = 6.
//  4. seed=0 loaded, burst_len=2 -> bytes 01,03 (zero-seed substitution); start with burst_len=0 ->
//     done one cycle after start, enable_out never high.
//  5. Reset asserted mid-RUN after 3 bytes -> next cycle all outputs zero, no done; new burst with
//     no reseed starts from lfsr=SEED_DEFAULT (first byte 01).
//  6. start/load_seed pulsed while busy -> ignored: burst length and byte sequence unchanged.

Source files
------------

// File: rtl/sample_vector_gen.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sample_vector_gen : seedable 32-bit LFSR byte-burst source with warm-up,
//                     hold and done/busy status.  Rev 1.0
// ---------------------------------------------------------------------------
module sample_vector_gen #(
  parameter int          WARM_CYCLES  = 10,
  parameter logic [31:0] SEED_DEFAULT = 32'h0000_0001,
  parameter int          LEN_W        = 10
) (
  input  logic             sim_clk,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] burst_len,
  input  logic             load_seed,
  input  logic [31:0]      seed,
  input  logic             hold,
  output logic [7:0]       data_out,
  output logic             enable_out,
  output logic             busy,
  output logic             done,
  output logic [LEN_W-1:0] vec_count
);

  localparam int WARM_W = (WARM_CYCLES > 1) ? $clog2(WARM_CYCLES) : 1;
  localparam logic [WARM_W-1:0] C_WARM_LAST = WARM_W'(WARM_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WARMUP = 2'd1,
    S_RUN    = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [31:0]        lfsr_q, lfsr_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [WARM_W-1:0]  warm_q, warm_d;
  logic [7:0]         data_q, data_d;
  logic               en_q, en_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [31:0]        lfsr_next;
  logic [LEN_W-1:0]   cnt_inc;

  assign lfsr_next = {lfsr_q[30:0], lfsr_q[31] ^ lfsr_q[21] ^ lfsr_q[1] ^ lfsr_q[0]};
  assign cnt_inc   = cnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    warm_d  = warm_q;
    data_d  = data_q;
    en_d    = 1'b0;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (load_seed) begin
          lfsr_d = (seed == 32'h0) ? 32'h0000_0001 : seed;
        end
        if (start) begin
          len_d   = burst_len;
          cnt_d   = '0;
          warm_d  = '0;
          state_d = (burst_len == '0) ? S_DONE : S_WARMUP;
        end
      end
      S_WARMUP: begin
        if (warm_q == C_WARM_LAST) begin
          state_d = S_RUN;
        end else begin
          warm_d = warm_q + 1'b1;
        end
      end
      S_RUN: begin
        if (!hold) begin
          en_d   = 1'b1;
          data_d = lfsr_q[7:0];
          lfsr_d = lfsr_next;
          cnt_d  = cnt_inc;
          if (cnt_inc == len_q) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Leaving RUN keeps busy up through the cycle that shows the final byte.
    busy_d = (state_d == S_WARMUP) || (state_d == S_RUN) || (state_q == S_RUN);
  end

  always_ff @(posedge sim_clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      lfsr_q  <= SEED_DEFAULT;
      len_q   <= '0;
      cnt_q   <= '0;
      warm_q  <= '0;
      data_q  <= 8'h00;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      warm_q  <= warm_d;
      data_q  <= data_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign data_out   = data_q;
  assign enable_out = en_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign vec_count  = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_sample_vector_gen.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_sample_vector_gen : table-driven burst checks plus reset-abort sequence.
// ---------------------------------------------------------------------------
module tb_sample_vector_gen;

  localparam int LEN_W = 10;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [LEN_W-1:0] burst_len;
  logic             load_seed;
  logic [31:0]      seed;
  logic             hold;
  logic [7:0]       data_out;
  logic             enable_out;
  logic             busy;
  logic             done;
  logic [LEN_W-1:0] vec_count;

  int checks   = 0;
  int failures = 0;
  logic [31:0] m_lfsr;

  sample_vector_gen #(
    .WARM_CYCLES (10),
    .SEED_DEFAULT(32'h0000_0001),
    .LEN_W       (LEN_W)
  ) dut (
    .sim_clk   (clk),
    .reset     (reset),
    .start     (start),
    .burst_len (burst_len),
    .load_seed (load_seed),
    .seed      (seed),
    .hold      (hold),
    .data_out  (data_out),
    .enable_out(enable_out),
    .busy      (busy),
    .done      (done),
    .vec_count (vec_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          load;
    logic [31:0] seed;
    int          len;
    int          hold_after;
    int          hold_len;
    int          inj_at;
    logic [31:0] head;      // first expected bytes, MSB byte first
    int          nhead;
    int          exp_first_k;
    int          exp_done_k;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] step(input logic [31:0] s);
    return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // k counts edges after the start edge; outputs are observed once per k.
  task automatic run_burst(input vec_t v);
    int k, nb, first_k, done_k, busy_bad, frozen_bad, hold_cnt, en_cnt;
    logic [7:0] last, first_b;
    k = 0; nb = 0; first_k = -1; done_k = -1;
    busy_bad = 0; frozen_bad = 0; hold_cnt = 0; en_cnt = 0;
    last = 8'h00; first_b = 8'h00;
    if (v.load) m_lfsr = (v.seed == 32'h0) ? 32'h1 : v.seed;
    start = 1'b1; load_seed = v.load; seed = v.seed; burst_len = LEN_W'(v.len);
    tick();
    start = 1'b0; load_seed = 1'b0; burst_len = '0;
    while (done_k < 0 && k < 300) begin
      start     = (k == v.inj_at);
      load_seed = (k == v.inj_at);
      seed      = 32'h0000_0055;
      burst_len = (k == v.inj_at) ? LEN_W'(2) : '0;
      if (enable_out) begin
        nb++; en_cnt++;
        if (first_k < 0) begin
          first_k = k;
          first_b = data_out;
        end
        if (nb <= v.nhead) chk("head_byte", data_out, v.head[31-8*(nb-1) -: 8]);
        chk("model_byte", data_out, m_lfsr[7:0]);
        m_lfsr = step(m_lfsr);
        chk("vec_count_run", vec_count, nb);
        last = data_out;
        if (nb == v.hold_after && v.hold_len > 0) begin
          hold = 1'b1;
          hold_cnt = v.hold_len;
        end
      end else if (busy && nb > 0 && data_out !== last) begin
        frozen_bad++;
      end
      if (v.len > 0 && nb < v.len && !busy) busy_bad++;
      if (done) begin
        done_k = k;
        chk("done_enable_low", enable_out, 1'b0);
        chk("done_busy_low", busy, 1'b0);
        chk("done_vec_count", vec_count, v.len);
      end else begin
        tick();
        k++;
        if (hold_cnt > 0) begin
          hold_cnt--;
          if (hold_cnt == 0) hold = 1'b0;
        end
      end
    end
    start = 1'b0; load_seed = 1'b0; hold = 1'b0;
    chk("done_cycle", done_k, v.exp_done_k);
    chk("first_enable_cycle", first_k, v.exp_first_k);
    chk("enable_cycles", en_cnt, v.len);
    chk("busy_throughout", busy_bad, 0);
    chk("data_frozen", frozen_bad, 0);
    if (v.nhead > 0) chk("first_byte", first_b, v.head[31:24]);
    tick();
    chk("done_one_cycle", done, 1'b0);
    chk("vec_count_held", vec_count, v.len);
  endtask

  vec_t tbl[6];
  vec_t post;

  initial begin
    reset = 1'b1; start = 1'b0; burst_len = '0; load_seed = 1'b0;
    seed = 32'h0; hold = 1'b0;
    m_lfsr = 32'h1;
    tbl[0] = '{1'b1, 32'h0000_0001, 4, -1, 0, -1, 32'h0103060D, 4, 11, 15};
    tbl[1] = '{1'b0, 32'h0,         6,  2, 3, -1, 32'h1B366DDB, 4, 11, 20};
    tbl[2] = '{1'b1, 32'h0000_0000, 2, -1, 0, -1, 32'h01030000, 2, 11, 13};
    tbl[3] = '{1'b0, 32'h0,         0, -1, 0, -1, 32'h00000000, 0, -1, 1};
    tbl[4] = '{1'b0, 32'h0,         5, -1, 0, 12, 32'h060D1B36, 4, 11, 16};
    tbl[5] = '{1'b1, 32'hDEADBEEF,  3, -1, 0, -1, 32'hEFDEBC00, 3, 11, 14};
    post   = '{1'b0, 32'h0,         2, -1, 0, -1, 32'h01030000, 2, 11, 13};

    repeat (10) tick();
    chk("rst_data_out", data_out, 8'h00);
    chk("rst_enable", enable_out, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_vec_count", vec_count, '0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 6; i++) run_burst(tbl[i]);

    // Abort a burst with reset after its third byte.
    begin
      int nb, k, stray;
      nb = 0; k = 0; stray = 0;
      start = 1'b1; burst_len = LEN_W'(8);
      tick();
      start = 1'b0; burst_len = '0;
      while (nb < 3 && k < 100) begin
        if (enable_out) nb++;
        if (nb < 3) begin
          tick();
          k++;
        end
      end
      chk("abort_reached_3_bytes", nb, 3);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("abort_data_out", data_out, 8'h00);
      chk("abort_enable", enable_out, 1'b0);
      chk("abort_busy", busy, 1'b0);
      chk("abort_done", done, 1'b0);
      chk("abort_vec_count", vec_count, '0);
      for (int j = 0; j < 15; j++) begin
        tick();
        if (done || enable_out || busy) stray++;
      end
      chk("abort_quiet", stray, 0);
      m_lfsr = 32'h1;
      run_burst(post);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
